// File: rtl/conv_ctrl_pkg.sv
// Shared types and sizing helpers for the conv_node sequencer.
//   state_e  : sequencer states
//   calc_n   : MAC steps per window (kernel rows * columns)
//   calc_iw  : index/address width covering 0..N (N is the bias address)
//   calc_cw  : window counter width (at least 1 bit)
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    BIAS  = 2'd2,
    LATCH = 2'd3
  } state_e;

  function automatic int unsigned calc_n(input int unsigned kh, input int unsigned kw);
    return kh * kw;
  endfunction

  function automatic int unsigned calc_iw(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned calc_cw(input int unsigned nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

endpackage

// File: rtl/conv_ctrl_out_reg.sv
// Result-side handshake register: tracks whether conv_node data holds an
// unconsumed result, the last-of-frame flag and the frame-done pulse.
// Ports:
//   clk_i, reset_n_i : clock, async active-low reset
//   start            : result is latched into the conv_node at the next edge
//   is_last          : the result being latched is the last window of a frame
//   ready            : downstream accepts the current result
//   valid            : unconsumed result present
//   last             : flag travelling with valid
//   frame_done       : one-cycle pulse after the last result is consumed
module conv_ctrl_out_reg (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic start,
  input  logic is_last,
  input  logic ready,
  output logic valid,
  output logic last,
  output logic frame_done
);

  // A start in the handshake cycle overwrites the consumed result, so valid stays set.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid      <= 1'b0;
      last       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= valid & ready & last;
      if (start) begin
        valid <= 1'b1;
        last  <= is_last;
      end else if (valid && ready) begin
        valid <= 1'b0;
        last  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/conv_node_ctrl.sv
// Sequencer driving a conv_node: accepts a kernel window, steps the MAC
// index over N weights, issues the bias step, then pulses start to latch
// the sum, and presents results downstream with per-frame last tracking.
// Ports:
//   clk_i, reset_n_i          : clock, async active-low reset
//   valid_i / ready_o         : upstream window handshake
//   win_load_o                : window register load (accepted handshake)
//   ps_o, add_bias_o, start_o : conv_node accumulate / bias / latch controls
//   input_index_o             : data index, always equal to weight_addr_o
//   weight_addr_o             : weight ROM address (N selects the bias)
//   valid_o / ready_i         : downstream result handshake
//   last_o                    : result is the last window of the frame
//   frame_done_o              : pulse after the last result is consumed
module conv_node_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter  int unsigned KERNEL_HEIGHT = 3,
  parameter  int unsigned KERNEL_WIDTH  = 2,
  parameter  int unsigned NUM_WINDOWS   = 8,
  localparam int unsigned N             = calc_n(KERNEL_HEIGHT, KERNEL_WIDTH),
  localparam int unsigned IW            = calc_iw(N)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic          win_load_o,
  output logic          ps_o,
  output logic          start_o,
  output logic          add_bias_o,
  output logic [IW-1:0] input_index_o,
  output logic [IW-1:0] weight_addr_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          last_o,
  output logic          frame_done_o
);

  localparam int unsigned CW = calc_cw(NUM_WINDOWS);

  state_e        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [IW-1:0] index;
  logic [CW-1:0] win_cnt;
  logic          is_last;

  // State and MAC index registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next state and conv_node controls.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    ready_o    = 1'b0;
    ps_o       = 1'b0;
    start_o    = 1'b0;
    add_bias_o = 1'b0;
    index      = '0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          idx_nxt   = '0;
          state_nxt = MAC;
        end
      end
      MAC: begin
        ps_o    = 1'b1;
        index   = idx;
        idx_nxt = idx + IW'(1);
        if (idx == IW'(N - 1)) begin
          state_nxt = BIAS;
        end
      end
      BIAS: begin
        ps_o       = 1'b1;
        add_bias_o = 1'b1;
        index      = IW'(N);
        state_nxt  = LATCH;
      end
      LATCH: begin
        // Hold off while an unconsumed result would be overwritten.
        if (!(valid_o && !ready_i)) begin
          start_o   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign win_load_o    = valid_i & ready_o;
  assign input_index_o = index;
  assign weight_addr_o = index;

  // Window position within the frame, advanced per latched result.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      win_cnt <= '0;
    end else if (start_o) begin
      win_cnt <= (win_cnt == CW'(NUM_WINDOWS - 1)) ? '0 : win_cnt + CW'(1);
    end
  end

  assign is_last = (win_cnt == CW'(NUM_WINDOWS - 1));

  conv_ctrl_out_reg u_out_reg (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .start      (start_o),
    .is_last    (is_last),
    .ready      (ready_i),
    .valid      (valid_o),
    .last       (last_o),
    .frame_done (frame_done_o)
  );

endmodule

// File: tb/tb_conv_node_ctrl.sv
// Bench for conv_node_ctrl paired with a behavioural conv_node.
module tb_conv_node_ctrl;

  localparam int unsigned KH = 3;
  localparam int unsigned KW = 2;
  localparam int unsigned NW = 8;
  localparam int unsigned N  = KH * KW;
  localparam int unsigned IW = 3;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic          valid_i;
  logic          ready_o;
  logic          win_load_o;
  logic          ps_o;
  logic          start_o;
  logic          add_bias_o;
  logic [IW-1:0] input_index_o;
  logic [IW-1:0] weight_addr_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_o;
  logic          frame_done_o;

  always #5 clk = ~clk;

  conv_node_ctrl #(
    .KERNEL_HEIGHT (KH),
    .KERNEL_WIDTH  (KW),
    .NUM_WINDOWS   (NW)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .win_load_o    (win_load_o),
    .ps_o          (ps_o),
    .start_o       (start_o),
    .add_bias_o    (add_bias_o),
    .input_index_o (input_index_o),
    .weight_addr_o (weight_addr_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .last_o        (last_o),
    .frame_done_o  (frame_done_o)
  );

  // Behavioural conv_node driven by the controller outputs.
  int weights[N+1];
  int cur_data[N];
  int wreg[N+1];
  int acc;
  int data_o;

  always @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc    <= 0;
      data_o <= 0;
    end else begin
      if (win_load_o) begin
        for (int i = 0; i < int'(N); i++) wreg[i] <= cur_data[i];
      end
      if (start_o) begin
        data_o <= acc;
        acc    <= 0;
      end else if (ps_o) begin
        acc <= acc + (add_bias_o ? weights[N] : wreg[input_index_o] * weights[weight_addr_o]);
      end
    end
  end

  // Reference: windows in flight, results awaiting consumption.
  int checks   = 0;
  int failures = 0;
  int phase    = -1;   // cycles since acceptance, -1 when idle
  int pending  = 0;    // latched but unconsumed results
  int exp_q[$];
  bit last_q[$];
  int win_count = 0;
  bit fd_exp    = 1'b0;
  bit rnd_data  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic new_data();
    for (int i = 0; i < int'(N); i++) cur_data[i] = int'($urandom_range(0, 15));
  endtask

  function automatic int window_sum();
    int s = weights[N];
    for (int i = 0; i < int'(N); i++) s += cur_data[i] * weights[i];
    return s;
  endfunction

  task automatic model_reset();
    phase     = -1;
    pending   = 0;
    exp_q.delete();
    last_q.delete();
    win_count = 0;
    fd_exp    = 1'b0;
  endtask

  // One clock cycle: drive, check against the reference, advance it.
  task automatic run_cycle(input logic v, input logic r);
    int   exp_idx;
    logic exp_start;
    logic accept;
    valid_i = v;
    ready_i = r;
    #1;
    accept    = v && (phase < 0);
    exp_idx   = (phase >= 1 && phase <= int'(N)) ? phase - 1 : ((phase == int'(N) + 1) ? int'(N) : 0);
    exp_start = (phase >= int'(N) + 2) && !((pending > 0) && !r);
    check("ready_o",    32'(ready_o),    32'(phase < 0));
    check("win_load_o", 32'(win_load_o), 32'(accept));
    check("ps_o",       32'(ps_o),       32'(phase >= 1 && phase <= int'(N) + 1));
    check("add_bias_o", 32'(add_bias_o), 32'(phase == int'(N) + 1));
    check("index",      32'(input_index_o), 32'(exp_idx));
    check("addr",       32'(weight_addr_o), 32'(exp_idx));
    check("start_o",    32'(start_o),    32'(exp_start));
    check("valid_o",    32'(valid_o),    32'(pending > 0));
    check("frame_done", 32'(frame_done_o), 32'(fd_exp));
    check("ps_start_excl", 32'(ps_o & start_o), 32'(0));
    check("start_while_blocked", 32'(start_o & valid_o & ~ready_i), 32'(0));
    fd_exp = 1'b0;
    if ((pending > 0) && r && (exp_q.size() > 0)) begin
      check("result_data", 32'(data_o), 32'(exp_q[0]));
      check("result_last", 32'(last_o), 32'(last_q[0]));
      fd_exp = last_q[0];
      void'(exp_q.pop_front());
      void'(last_q.pop_front());
      pending--;
    end
    if (exp_start) begin
      pending++;
      phase = -1;
    end else if (phase >= 1) begin
      phase++;
    end
    if (accept) begin
      exp_q.push_back(window_sum());
      last_q.push_back((win_count % int'(NW)) == int'(NW) - 1);
      win_count++;
      phase = 1;
    end
    @(posedge clk);
    #1;
    if (accept && rnd_data) new_data();
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (phase < 0 && pending == 0) break;
      run_cycle(1'b0, 1'b1);
    end
    check("drained", 32'(phase < 0 && pending == 0), 32'(1));
  endtask

  initial begin
    reset_n_i = 1'b0;
    valid_i   = 1'b0;
    ready_i   = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      weights[i]  = i + 1;
      cur_data[i] = 1;
    end
    weights[N] = 10;
    #1;
    check("rst_ready", 32'(ready_o), 32'(1));
    check("rst_ps",    32'(ps_o),    32'(0));
    check("rst_start", 32'(start_o), 32'(0));
    check("rst_valid", 32'(valid_o), 32'(0));
    check("rst_last",  32'(last_o),  32'(0));
    check("rst_index", 32'(input_index_o), 32'(0));
    @(posedge clk);
    #3 reset_n_i = 1'b1;
    @(posedge clk);
    #1;

    // Single window: 1*(1+..+6) + 10.
    run_cycle(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b1);
    check("single_valid", 32'(valid_o), 32'(1));
    check("single_data",  32'(data_o),  32'(31));
    run_cycle(1'b0, 1'b1);

    // Backpressure: second window stalls in latch until ready returns.
    run_cycle(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0);
    for (int i = 0; i < int'(N); i++) cur_data[i] = 2;
    run_cycle(1'b1, 1'b0);
    for (int i = 0; i < 11; i++) run_cycle(1'b0, 1'b0);
    check("bp_hold_data", 32'(data_o), 32'(31));
    run_cycle(1'b0, 1'b1);
    check("bp_valid_kept", 32'(valid_o), 32'(1));
    check("bp_new_data",   32'(data_o),  32'(52));
    run_cycle(1'b0, 1'b1);
    drain();

    // Random weights and data from here on.
    for (int i = 0; i <= int'(N); i++) weights[i] = int'($urandom_range(0, 15));
    rnd_data = 1'b1;
    new_data();

    // Back-to-back windows with free-flowing output.
    for (int i = 0; i < 27; i++) run_cycle(1'b1, 1'b1);

    // Random traffic across several frames.
    for (int i = 0; i < 400; i++) begin
      run_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end
    drain();

    // Reset in the middle of MAC.
    run_cycle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1);
    check("pre_reset_idx", 32'(input_index_o), 32'(3));
    reset_n_i = 1'b0;
    #1;
    model_reset();
    check("mid_rst_ready", 32'(ready_o), 32'(1));
    check("mid_rst_ps",    32'(ps_o),    32'(0));
    check("mid_rst_index", 32'(input_index_o), 32'(0));
    check("mid_rst_valid", 32'(valid_o), 32'(0));
    check("mid_rst_bias",  32'(add_bias_o), 32'(0));
    @(posedge clk);
    #3 reset_n_i = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b1);
    run_cycle(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b1);
    drain();
    check("final_queue_empty", 32'(exp_q.size()), 32'(0));
    check("final_windows", 32'(win_count), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
